// File: rtl/tdp18k_pkg.sv
// tdp18k_pkg: TDP18K width codes and reader FSM states
package tdp18k_pkg;
  localparam logic [2:0] MODE_18 = 3'b010;
  localparam logic [2:0] MODE_9 = 3'b100;
  localparam logic [2:0] MODE_4 = 3'b110;
  localparam logic [2:0] MODE_2 = 3'b011;
  localparam logic [2:0] MODE_1 = 3'b001;
  typedef enum logic [1:0] {FLUSH, SETTLE, RUN} state_e;
endpackage

// File: rtl/tdp18k_fifo_reader_if.sv
// tdp18k_fifo_reader_if: valid/ready word stream
interface tdp18k_fifo_reader_if;
  logic valid;
  logic ready;
  logic [17:0] data;
  modport master(output valid, data, input ready);
  modport slave(input valid, data, output ready);
endinterface

// File: rtl/tdp18k_rd_skid.sv
// tdp18k_rd_skid: 3-entry read buffer absorbing the RAM read latency
module tdp18k_rd_skid (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic clr_i,
  input  logic push_i,
  input  logic pop_i,
  input  logic [17:0] data_i,
  output logic [1:0] cnt_o,
  output logic [17:0] head_o
);
  logic [17:0] mem_q [3];
  logic [1:0] wp_q, rp_q, cnt_q;
  always_ff @(posedge clk_i or negedge rst_ni)
    if (!rst_ni) begin
      mem_q <= '{default: '0};
      wp_q <= '0;
      rp_q <= '0;
      cnt_q <= '0;
    end else if (clr_i) begin
      wp_q <= '0;
      rp_q <= '0;
      cnt_q <= '0;
    end else begin
      if (push_i) mem_q[wp_q] <= data_i;
      wp_q <= push_i ? (wp_q == 2'd2 ? 2'd0 : wp_q + 2'd1) : wp_q;
      rp_q <= pop_i ? (rp_q == 2'd2 ? 2'd0 : rp_q + 2'd1) : rp_q;
      cnt_q <= cnt_q + 2'(push_i) - 2'(pop_i);
    end
  assign cnt_o = cnt_q;
  assign head_o = mem_q[rp_q];
  a_no_overflow: assert property (@(posedge clk_i) disable iff (!rst_ni)
    !(push_i && !pop_i && !clr_i && cnt_q == 2'd3));
endmodule

// File: rtl/tdp18k_fifo_reader.sv
// tdp18k_fifo_reader: TDP18K FIFO read controller presenting words on a bubble-free valid/ready stream
module tdp18k_fifo_reader
  import tdp18k_pkg::*;
#(
  parameter logic [2:0] RMODE = MODE_18,
  parameter int FLUSH_CYCLES = 4,
  parameter int CNT_W = 16
) (
  input  logic CLK_i,
  input  logic RST_ni,
  input  logic EMPTY_i,
  input  logic EPO_i,
  input  logic UNDERRUN_i,
  input  logic [17:0] RDATA_i,
  output logic REN_o,
  output logic [2:0] RMODE_o,
  output logic FLUSH_no,
  input  logic FLUSH_REQ_i,
  tdp18k_fifo_reader_if.master m,
  output logic [CNT_W-1:0] RD_COUNT_o,
  output logic ERR_o
);
  localparam int FC_W = $clog2(FLUSH_CYCLES);
  state_e state_q, state_d;
  logic [FC_W-1:0] fcnt_q, fcnt_d;
  logic [CNT_W-1:0] rd_count_q, rd_count_d;
  logic ren_q, err_q, err_d, clr, fire;
  logic [1:0] cnt;
  logic [17:0] wdata, head;
  always_ff @(posedge CLK_i or negedge RST_ni)
    if (!RST_ni) begin
      state_q <= FLUSH;
      fcnt_q <= FC_W'(FLUSH_CYCLES - 1);
      rd_count_q <= '0;
      ren_q <= 1'b0;
      err_q <= 1'b0;
    end else begin
      state_q <= state_d;
      fcnt_q <= fcnt_d;
      rd_count_q <= rd_count_d;
      ren_q <= REN_o;
      err_q <= err_d;
    end
  always_comb begin
    state_d = state_q;
    fcnt_d = FC_W'(FLUSH_CYCLES - 1);
    if (FLUSH_REQ_i) state_d = FLUSH;
    else if (state_q == FLUSH) begin
      state_d = fcnt_q == '0 ? SETTLE : FLUSH;
      fcnt_d = fcnt_q - FC_W'(1);
    end else if (state_q == SETTLE) state_d = RUN;
  end
  // flags lag REN by a cycle, so EPO with a read already in flight means the FIFO is drained
  assign REN_o = state_q == RUN && !FLUSH_REQ_i && !EMPTY_i && !(EPO_i && ren_q) &&
                 ({1'b0, cnt} + {2'b0, ren_q} < 3'd3);
  assign clr = state_q != RUN || FLUSH_REQ_i;
  assign fire = m.valid && m.ready;
  assign rd_count_d = clr ? '0 : rd_count_q + CNT_W'(fire);
  assign err_d = err_q || UNDERRUN_i || (REN_o && EMPTY_i);
  assign wdata = RMODE == MODE_9 ? {9'b0, RDATA_i[16], RDATA_i[7:0]} : RDATA_i;
  tdp18k_rd_skid u_skid (
    .clk_i(CLK_i),
    .rst_ni(RST_ni),
    .clr_i(clr),
    .push_i(ren_q),
    .pop_i(fire),
    .data_i(wdata),
    .cnt_o(cnt),
    .head_o(head)
  );
  assign m.valid = cnt != 2'd0;
  assign m.data = head;
  assign RMODE_o = RMODE;
  assign FLUSH_no = state_q != FLUSH;
  assign RD_COUNT_o = rd_count_q;
  assign ERR_o = err_q;
endmodule
